mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port memory between the core's instruction-fetch port and its data (load/store) port.
//  Sits between riscv_core and the memory, replacing the current two-port memory model.
//  Grants one requester at a time and routes the memory's acknowledge and read data back to the owner.
//  Data has priority over fetch, with a starvation guard for fetch and a watchdog for memory that never acknowledges.
// PARAMETERS
//  ADDR_W      32   address width
//  DATA_W      32   data width
//  MAX_STREAK  4    max consecutive data grants while a fetch is pending (>=1)
//  TIMEOUT     255  cycles in BUSY without m_ack before abort; 0 disables the watchdog
// PORTS
//  clk       in   1        single clock, rising edge
//  rst       in   1        asynchronous, active-low reset
//  if_req    in   1        fetch request; held until if_ack or if_err
//  if_addr   in   ADDR_W   fetch address
//  if_rdata  out  DATA_W   fetch data; valid only while if_ack=1
//  if_ack    out  1        one-cycle pulse: fetch done
//  if_err    out  1        one-cycle pulse: fetch aborted by watchdog
//  d_req     in   1        data request; held until d_ack or d_err
//  d_we      in   1        0 read, 1 write
//  d_addr    in   ADDR_W   data address
//  d_wdata   in   DATA_W   write data
//  d_wstrb   in   DATA_W/8 byte enables for writes
//  d_rdata   out  DATA_W   load data; valid only while d_ack=1
//  d_ack     out  1        one-cycle pulse: data access done
//  d_err     out  1        one-cycle pulse: data access aborted
//  m_req     out  1        memory request, held until m_ack
//  m_we      out  1        memory write enable
//  m_addr    out  ADDR_W   memory address
//  m_wdata   out  DATA_W   memory write data
//  m_wstrb   out  DATA_W/8 memory byte enables (all 0 for reads)
//  m_rdata   in   DATA_W   memory read data, valid with m_ack
//  m_ack     in   1        memory done; may assert in the first cycle of m_req
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state=IDLE; streak=0; watchdog=0.
//   - All outputs 0; any in-flight transaction is dropped and never acknowledged.
//  FSM states: IDLE, BUSY.
//  IDLE:
//   - If any request is present, pick a winner, capture its we/addr/wdata/wstrb into registers, set owner, go to BUSY.
//   - Fetch requests capture we=0, wstrb=0.
//  Arbitration:
//   - Data wins, except fetch wins when if_req=1 and streak==MAX_STREAK.
//   - streak increments on a data grant while if_req=1; clears on a fetch grant or when if_req=0.
//  BUSY:
//   - m_* is driven from the captured registers; m_req=1.
//   - On m_ack: pulse the owner's ack and pass m_rdata combinationally to the owner's rdata; go to IDLE.
//   - Always one IDLE bubble between transactions.
//  Latency: request seen at edge N -> m_req from N+1 -> owner ack in the same cycle m_ack arrives (minimum 1 cycle).
//  Non-owner: ack/err/rdata stay 0.
//  Watchdog:
//   - Counts cycles in BUSY without m_ack.
//   - At TIMEOUT: drop m_req, pulse the owner's err, go to IDLE.
//   - m_ack in the same cycle as timeout wins: ack is issued, not err.
//  Requester drops req before its ack (protocol violation):
//   - The memory transaction still completes; the ack is suppressed; no other side effect.
//  Input changes while BUSY have no effect, because the transaction runs from captured registers.
// STRUCTURE
//  - Add to common.v: state encodings `ARB_IDLE/`ARB_BUSY, owner IDs `ARB_OWN_IF/`ARB_OWN_D.
//  - One sub-module: mem_arb_watchdog (counter, clear/enable, timeout pulse, TIMEOUT=0 disables).
// TESTING
//  1. Reset with d_req=if_req=1: all outputs 0 while rst=0. After release, the data request is granted first (m_we=d_we).
//  2. Fetch only, if_addr=0x100, memory acks on the first cycle with 0x13:
//     m_req and m_addr=0x100 one cycle after the request; if_ack=1 with if_rdata=0x13 in that same cycle.
//  3. Both requests held continuously, MAX_STREAK=4, memory acks in 1 cycle:
//     grant order D,D,D,D,IF,D,D,D,D,IF...
//  4. Data write d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, memory ack after 3 cycles:
//     - m_* stable for 3 cycles; d_addr changed mid-transaction is ignored.
//     - d_ack is a single-cycle pulse.
//  5. TIMEOUT=8, memory never acks: d_err pulses 8 cycles after m_req rises; m_req drops; a pending fetch is then granted.
//  6. Assert rst=0 mid-BUSY: m_req falls without waiting for a clock edge; no ack after release; the next request is served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and arbitration helper for the single-port memory arbiter.
package mem_arbiter_pkg;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    localparam logic ARB_OWN_IF = 1'b0;
    localparam logic ARB_OWN_D  = 1'b1;

    // Data normally wins; fetch wins when alone or once the data streak is exhausted.
    function automatic logic fetch_wins(input logic if_req, input logic d_req,
                                        input logic streak_full);
        return if_req && (!d_req || streak_full);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts BUSY cycles without a memory acknowledge; pulses timeout at the limit.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A limit of zero turns the watchdog off entirely.
    assign timeout = (TIMEOUT != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one single-port memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_err,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [0:0]          state;
    logic                owner;
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [DATA_W/8-1:0] cap_wstrb;
    logic [SW-1:0]       streak;

    logic busy, any_req, streak_full, pick_if, timeout, done;
    logic own_if, own_d;

    assign busy        = (state == ARB_BUSY);
    assign any_req     = if_req || d_req;
    assign streak_full = (streak == SW'(MAX_STREAK));
    assign pick_if     = fetch_wins(if_req, d_req, streak_full);
    assign done        = busy && (m_ack || timeout);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            owner     <= ARB_OWN_IF;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
        end else if (!busy) begin
            if (any_req) begin
                state     <= ARB_BUSY;
                owner     <= pick_if ? ARB_OWN_IF : ARB_OWN_D;
                cap_we    <= pick_if ? 1'b0 : d_we;
                cap_addr  <= pick_if ? if_addr : d_addr;
                cap_wdata <= pick_if ? '0 : d_wdata;
                cap_wstrb <= (pick_if || !d_we) ? '0 : d_wstrb;
            end
        end else if (done) begin
            state <= ARB_IDLE;
        end
    end

    // Streak only tracks data grants taken while a fetch was waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (!if_req) begin
            streak <= '0;
        end else if (!busy && any_req) begin
            streak <= pick_if ? '0 : streak + 1'b1;
        end
    end

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!busy),
        .en      (busy && !m_ack),
        .timeout (timeout)
    );

    assign m_req   = busy;
    assign m_we    = busy && cap_we;
    assign m_addr  = busy ? cap_addr  : '0;
    assign m_wdata = busy ? cap_wdata : '0;
    assign m_wstrb = busy ? cap_wstrb : '0;

    assign own_if = busy && (owner == ARB_OWN_IF);
    assign own_d  = busy && (owner == ARB_OWN_D);

    // A requester that abandoned its request gets no acknowledge.
    assign if_ack   = own_if && m_ack && if_req;
    assign d_ack    = own_d  && m_ack && d_req;
    assign if_err   = own_if && timeout;
    assign d_err    = own_d  && timeout;
    assign if_rdata = if_ack ? m_rdata : '0;
    assign d_rdata  = d_ack  ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a simple latency-programmable memory.
module tb_mem_arbiter;

    logic        clk, rst;
    logic        if_req, if_ack, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks after mem_lat cycles of m_req (0 = first cycle, negative = never).
    int mem_lat = 0;
    int mcnt = 0;
    always @(posedge clk) begin
        if (!m_req || m_ack) mcnt <= 0;
        else mcnt <= mcnt + 1;
    end
    assign m_ack   = m_req && (mem_lat >= 0) && (mcnt == mem_lat);
    assign m_rdata = (m_addr == 32'h100) ? 32'h13 : ~m_addr;

    typedef struct {
        int          kind;   // 0 if_ack, 1 d_ack, 2 if_err, 3 d_err
        logic [31:0] rdata;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int resp_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] rdata, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t e;
        e.kind = kind; e.rdata = rdata; e.we = we;
        e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input int n);
        int t;
        t = 0;
        while (resp_cnt < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (resp_cnt < n) begin
            checks++;
            failures++;
            $display("FAIL wait_resp act=%0d exp=%0d", resp_cnt, n);
        end
        #1;
    endtask

    // Monitor: tracks the granted memory command and scores every response pulse.
    logic        mreq_prev = 1'b0;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_wstrb;
    initial begin
        forever begin
            int   nresp, kind;
            logic [31:0] act_rd;
            exp_t e;
            @(negedge clk);
            if (!rst) begin
                mreq_prev = 1'b0;
                continue;
            end
            if (m_req && !mreq_prev)
                {lat_we, lat_addr, lat_wdata, lat_wstrb} = {m_we, m_addr, m_wdata, m_wstrb};
            else if (m_req)
                chk("m_stable", {m_we, m_addr, m_wdata, m_wstrb}, {lat_we, lat_addr, lat_wdata, lat_wstrb});
            mreq_prev = m_req;
            chk("nonowner_rdata", {(if_ack ? 32'h0 : if_rdata), (d_ack ? 32'h0 : d_rdata)}, 64'h0);
            nresp = int'(if_ack) + int'(d_ack) + int'(if_err) + int'(d_err);
            chk("one_pulse", nresp > 1, 0);
            if (nresp != 0) begin
                kind   = if_ack ? 0 : d_ack ? 1 : if_err ? 2 : 3;
                act_rd = (kind == 0) ? if_rdata : (kind == 1) ? d_rdata : (if_rdata | d_rdata);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp act=%0d exp=none", kind);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_kind", kind, e.kind);
                    chk("resp_rdata", act_rd, e.rdata);
                    chk("resp_mem", {lat_we, lat_addr, lat_wdata, lat_wstrb},
                        {e.we, e.addr, e.wdata, e.wstrb});
                end
                resp_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=%0d exp=%0d", resp_cnt, -1);
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1111_2222; d_wstrb = 4'hF;
        mem_lat = 0;

        // 1: outputs quiet under reset, data granted first after release
        repeat (3) @(negedge clk);
        chk("rst_mem", {m_req, m_we, m_addr, m_wdata, m_wstrb}, '0);
        chk("rst_resp", {if_ack, if_err, d_ack, d_err, if_rdata, d_rdata}, '0);
        push(1, 32'hFFFF_FFEF, 1'b1, 32'h10, 32'h1111_2222, 4'hF);
        push(0, 32'hFFFF_FFDF, 1'b0, 32'h20, 32'h0, 4'h0);
        base = resp_cnt;
        rst = 1'b1;
        wait_resp(base + 1);
        d_req = 1'b0;
        wait_resp(base + 2);
        if_req = 1'b0;
        @(posedge clk); #1;

        // 2: single-cycle fetch latency
        if_req = 1'b1; if_addr = 32'h100;
        push(0, 32'h13, 1'b0, 32'h100, 32'h0, 4'h0);
        @(negedge clk);
        chk("t2_not_early", m_req, 1'b0);
        @(negedge clk);
        chk("t2_ack_cycle", {m_req, m_addr, if_ack, if_rdata}, {1'b1, 32'h100, 1'b1, 32'h13});
        @(posedge clk); #1;
        if_req = 1'b0;
        @(posedge clk); #1;

        // 3: both held, grant order D,D,D,D,IF twice
        d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0; d_wstrb = 4'hF;
        if_addr = 32'h400;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) push(1, 32'hFFFF_FCFF, 1'b0, 32'h300, 32'h0, 4'h0);
            push(0, 32'hFFFF_FBFF, 1'b0, 32'h400, 32'h0, 4'h0);
        end
        base = resp_cnt;
        d_req = 1'b1; if_req = 1'b1;
        wait_resp(base + 10);
        d_req = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;

        // 4: slow write, address change mid-transaction ignored
        mem_lat = 3;
        d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        push(1, 32'hFFFF_FDFF, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011);
        base = resp_cnt;
        d_req = 1'b1;
        repeat (3) @(negedge clk);
        d_addr = 32'h204;
        wait_resp(base + 1);
        chk("t4_pulse", d_ack, 1'b0);
        d_req = 1'b0;
        @(posedge clk); #1;

        // 5: watchdog abort of data, then the pending fetch is served
        mem_lat = -1;
        d_we = 1'b0; d_addr = 32'h500; d_wdata = 32'h0;
        if_addr = 32'h600;
        push(3, 32'h0, 1'b0, 32'h500, 32'h0, 4'h0);
        push(0, 32'hFFFF_F9FF, 1'b0, 32'h600, 32'h0, 4'h0);
        base = resp_cnt;
        d_req = 1'b1; if_req = 1'b1;
        repeat (9) @(negedge clk);
        chk("t5_before_err", {m_req, d_err}, 2'b10);
        @(negedge clk);
        chk("t5_err", d_err, 1'b1);
        @(posedge clk); #1;
        chk("t5_mreq_drop", m_req, 1'b0);
        d_req = 1'b0; mem_lat = 0;
        wait_resp(base + 2);
        if_req = 1'b0;
        @(posedge clk); #1;

        // 6: asynchronous reset mid-transaction, then normal service
        mem_lat = -1;
        d_we = 1'b1; d_addr = 32'h700; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
        d_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_busy", m_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_mreq", m_req, 1'b0);
        exp_q.delete();
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_lat = 1;
        d_we = 1'b0; d_addr = 32'h800; d_wdata = 32'h0;
        push(1, 32'hFFFF_F7FF, 1'b0, 32'h800, 32'h0, 4'h0);
        base = resp_cnt;
        d_req = 1'b1;
        wait_resp(base + 1);
        d_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        chk("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
